l2_amo_unit: RTL
================

# l2_amo_unit

Sequencing stage for atomic memory operations in the Spandex L2. Accepts one AMO request at a time and fetches the target line from the L2 data array. Computes the updated line through a combinational AMO ALU, writes the line back, and returns the pre-operation value to the requester. Sits between the L2 request dispatch and the data-array read/write ports; strictly one transaction in flight.

## Interface
Parameters:
- `LINE_ADDR_W`, 32: width of the line address.

Ports:
- `clk`  in  1  clock; all state on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  AMO request valid.
- `req_ready`  out  1  block idle and able to accept a request.
- `req_addr`  in  `LINE_ADDR_W`  target line address.
- `req_w_off`  in  `word_offset_t`  word within the line.
- `req_b_off`  in  `byte_offset_t`  byte within the word.
- `req_hsize`  in  `hsize_t`  `WORD_32` means 32-bit; any other value means 64-bit.
- `req_amo`  in  `amo_t`  operation code (`AMO_*`).
- `req_word`  in  `word_t`  operand.
- `rd_valid` out 1 / `rd_ready` in 1 / `rd_addr` out `LINE_ADDR_W`  line read request.
- `rd_data_valid` in 1 / `rd_data` in `line_t`  read data; no backpressure.
- `wr_valid` out 1 / `wr_ready` in 1 / `wr_addr` out `LINE_ADDR_W` / `wr_line` out `line_t`  line write.
- `rsp_valid` out 1 / `rsp_ready` in 1 / `rsp_word` out `word_t`  old value returned to the requester.

## Operation
- States: `IDLE`, `RD_REQ`, `RD_WAIT`, `FINISH`.
- `IDLE`: `req_ready`=1. On `req_valid`, register all request fields, then go to `RD_REQ`.
- `RD_REQ`: `rd_valid`=1, `rd_addr`=captured address. On `rd_ready`, go to `RD_WAIT`.
- `RD_WAIT`: on `rd_data_valid`, register the old value and the updated line, then go to `FINISH`. `rd_data_valid` in any other state is ignored.
- `FINISH`: `wr_valid` and `rsp_valid` assert together. Each drops after its own handshake; the done flags are per channel.
  - Return to `IDLE` on the cycle the last outstanding handshake completes.
  - If both handshakes occur in the same cycle, return to `IDLE` immediately.
- Offsets:
  - Bit offset = `BITS_PER_WORD`·`w_off` + 8·`b_off`.
  - `b_off` is aligned down: low 2 bits are forced to 0 for 32-bit, low 3 bits for 64-bit.
- ALU, on a size-bit field:
  - SWAP → word.
  - ADD → line+word, modulo 2^size.
  - AND → line&word; OR → line|word; XOR → line^word.
  - MAX/MIN → signed compare; MAXU/MINU → unsigned compare.
  - Unknown opcode leaves the line unchanged.
  - Bits outside the field always pass through unchanged.
- `rsp_word` = old field value. For 32-bit, it is sign-extended to 64 bits.

## Timing
- Reset: state `IDLE`, `req_ready`=1, and all other outputs 0 (`rd_valid`, `wr_valid`, `rsp_valid`, `rd_addr`, `wr_addr`, `wr_line`, `rsp_word`). Reset mid-transaction abandons the transaction with no write issued.
- With zero-stall handshakes:
  - Request accepted in cycle 0.
  - `rd_valid` in cycle 1.
  - Read data in cycle N ≥ 2.
  - `wr_valid`/`rsp_valid` in cycle N+1.
  - `req_ready` in cycle N+2.
- Minimum turnaround between requests is 4 cycles.
- `rd_valid`, `wr_valid` and `rsp_valid` hold stable with their payloads until handshake (AXI-style).
- Outputs are registered; there is no combinational path from `req_*` to any output.

## Structure
- State encoding enum and `amo_t` opcode constants go in the shared `spandex_types`/`spandex_consts` package, alongside `word_t`, `line_t`, `hsize_t` and `word_offset_t`.
- One sub-module, `l2_amo_alu`: purely combinational; takes line, word, offsets, size and op; returns updated line and sign-extended old value.
- The FSM lives in `l2_amo_unit`.

## Test plan
- 64-bit ADD, w_off=1, old=0x0000_0000_0000_0005, word=3 → written field 0x8; other word unchanged; `rsp_word`=5.
- 32-bit MIN, b_off=4, old field 0x8000_0000, word=1 → field unchanged; `rsp_word`=0xFFFF_FFFF_8000_0000.
- 32-bit MINU, same values → field 0x0000_0001; low 32 bits untouched.
- Stall `wr_ready` 3 cycles with `rsp_ready`=1 → rsp completes first; `wr_valid`/`wr_line` stable for 3 cycles; `req_ready` the cycle after the write handshake.
- Stall `rd_ready` 2 cycles, then `rd_data_valid` 4 cycles later → `rd_addr` stable throughout; completion as specified.
- Assert `rst` low in `RD_WAIT`, then release and deliver a stray `rd_data_valid` → no `wr_valid`; `req_ready`=1.

Source files
------------

// File: rtl/l2_amo_unit_pkg.sv
// Shared types and constants for the L2 atomic-memory-operation stage.
// Holds line/word geometry, AMO opcodes, access sizes and the sequencer state encoding.
package l2_amo_unit_pkg;

    localparam int BITS_PER_WORD  = 64;
    localparam int WORDS_PER_LINE = 2;
    localparam int BITS_PER_LINE  = BITS_PER_WORD * WORDS_PER_LINE;

    typedef logic [BITS_PER_WORD-1:0] word_t;
    typedef logic [BITS_PER_LINE-1:0] line_t;
    typedef logic [0:0]               word_offset_t;
    typedef logic [2:0]               byte_offset_t;
    typedef logic [2:0]               hsize_t;
    typedef logic [3:0]               amo_t;

    localparam hsize_t WORD_32 = 3'b010;
    localparam hsize_t WORD_64 = 3'b011;

    localparam amo_t AMO_SWAP = 4'd0;
    localparam amo_t AMO_ADD  = 4'd1;
    localparam amo_t AMO_AND  = 4'd2;
    localparam amo_t AMO_OR   = 4'd3;
    localparam amo_t AMO_XOR  = 4'd4;
    localparam amo_t AMO_MAX  = 4'd5;
    localparam amo_t AMO_MAXU = 4'd6;
    localparam amo_t AMO_MIN  = 4'd7;
    localparam amo_t AMO_MINU = 4'd8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_REQ  = 2'd1,
        RD_WAIT = 2'd2,
        FINISH  = 2'd3
    } amo_state_t;

    // Byte offset is aligned down to the access size before it contributes to the bit offset.
    function automatic logic [6:0] field_bit_off(input word_offset_t w_off,
                                                 input byte_offset_t b_off,
                                                 input logic         is32);
        logic [2:0] b_al;
        b_al = is32 ? (b_off & 3'b100) : 3'b000;
        return {w_off, 6'b00_0000} | {1'b0, b_al, 3'b000};
    endfunction

endpackage

// File: rtl/l2_amo_unit_alu.sv
// Combinational AMO ALU: applies the operation to one 32/64-bit field of a line.
// Returns the updated line and the sign-extended pre-operation field value.
module l2_amo_alu
    import l2_amo_unit_pkg::*;
(
    input  line_t        line,
    input  word_t        word,
    input  word_offset_t w_off,
    input  byte_offset_t b_off,
    input  hsize_t       hsize,
    input  amo_t         amo,
    output line_t        new_line,
    output word_t        old_word
);

    logic       is32;
    logic [6:0] off;
    word_t      raw, a_s, b_s, a_u, b_u, res, mask;
    logic       lt_s, lt_u;

    always_comb begin
        is32 = (hsize == WORD_32);
        off  = field_bit_off(w_off, b_off, is32);
        raw  = word_t'(line >> off);
        a_s  = is32 ? {{32{raw[31]}}, raw[31:0]}   : raw;
        b_s  = is32 ? {{32{word[31]}}, word[31:0]} : word;
        a_u  = is32 ? {32'h0, raw[31:0]}           : raw;
        b_u  = is32 ? {32'h0, word[31:0]}          : word;
        lt_s = $signed(a_s) < $signed(b_s);
        lt_u = a_u < b_u;

        case (amo)
            AMO_SWAP: res = b_s;
            AMO_ADD:  res = a_s + b_s;
            AMO_AND:  res = a_s & b_s;
            AMO_OR:   res = a_s | b_s;
            AMO_XOR:  res = a_s ^ b_s;
            AMO_MAX:  res = lt_s ? b_s : a_s;
            AMO_MAXU: res = lt_u ? b_u : a_u;
            AMO_MIN:  res = lt_s ? a_s : b_s;
            AMO_MINU: res = lt_u ? a_u : b_u;
            default:  res = a_s;
        endcase

        // Upper half of a 32-bit result is masked off so neighbouring bits pass through.
        mask     = is32 ? 64'h0000_0000_FFFF_FFFF : '1;
        new_line = (line & ~(line_t'(mask) << off)) | (line_t'(res & mask) << off);
        old_word = a_s;
    end

endmodule

// File: rtl/l2_amo_unit.sv
// AMO sequencing stage: read line, apply AMO, write line back and return old value.
// Strictly one transaction in flight; all outputs come from registers.
//
// state   | meaning
// IDLE    | ready for a new request
// RD_REQ  | issuing the line read
// RD_WAIT | waiting for read data
// FINISH  | write and response outstanding until both handshake
module l2_amo_unit
    import l2_amo_unit_pkg::*;
#(
    parameter int LINE_ADDR_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [LINE_ADDR_W-1:0] req_addr,
    input  word_offset_t           req_w_off,
    input  byte_offset_t           req_b_off,
    input  hsize_t                 req_hsize,
    input  amo_t                   req_amo,
    input  word_t                  req_word,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [LINE_ADDR_W-1:0] rd_addr,
    input  logic                   rd_data_valid,
    input  line_t                  rd_data,
    output logic                   wr_valid,
    input  logic                   wr_ready,
    output logic [LINE_ADDR_W-1:0] wr_addr,
    output line_t                  wr_line,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output word_t                  rsp_word
);

    amo_state_t             state_q, state_d;
    logic [LINE_ADDR_W-1:0] addr_q;
    word_offset_t           w_off_q;
    byte_offset_t           b_off_q;
    hsize_t                 hsize_q;
    amo_t                   amo_q;
    word_t                  word_q;
    line_t                  wr_line_q;
    word_t                  rsp_word_q;
    logic                   wr_done_q, rsp_done_q;
    logic                   wr_hs, rsp_hs;
    line_t                  alu_line;
    word_t                  alu_old;

    l2_amo_alu u_alu (
        .line     (rd_data),
        .word     (word_q),
        .w_off    (w_off_q),
        .b_off    (b_off_q),
        .hsize    (hsize_q),
        .amo      (amo_q),
        .new_line (alu_line),
        .old_word (alu_old)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        req_ready = (state_q == IDLE);
        rd_valid  = (state_q == RD_REQ);
        wr_valid  = (state_q == FINISH) && !wr_done_q;
        rsp_valid = (state_q == FINISH) && !rsp_done_q;
        wr_hs     = wr_valid && wr_ready;
        rsp_hs    = rsp_valid && rsp_ready;
        case (state_q)
            IDLE:    if (req_valid)     state_d = RD_REQ;
            RD_REQ:  if (rd_ready)      state_d = RD_WAIT;
            RD_WAIT: if (rd_data_valid) state_d = FINISH;
            FINISH:  if ((wr_done_q || wr_hs) && (rsp_done_q || rsp_hs)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q     <= '0;
            w_off_q    <= '0;
            b_off_q    <= '0;
            hsize_q    <= '0;
            amo_q      <= '0;
            word_q     <= '0;
            wr_line_q  <= '0;
            rsp_word_q <= '0;
            wr_done_q  <= 1'b0;
            rsp_done_q <= 1'b0;
        end else begin
            if (state_q == IDLE && req_valid) begin
                addr_q  <= req_addr;
                w_off_q <= req_w_off;
                b_off_q <= req_b_off;
                hsize_q <= req_hsize;
                amo_q   <= req_amo;
                word_q  <= req_word;
            end
            if (state_q == RD_WAIT && rd_data_valid) begin
                wr_line_q  <= alu_line;
                rsp_word_q <= alu_old;
                wr_done_q  <= 1'b0;
                rsp_done_q <= 1'b0;
            end
            if (wr_hs)  wr_done_q  <= 1'b1;
            if (rsp_hs) rsp_done_q <= 1'b1;
        end
    end

    assign rd_addr  = addr_q;
    assign wr_addr  = addr_q;
    assign wr_line  = wr_line_q;
    assign rsp_word = rsp_word_q;

endmodule
